// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 16;
    localparam int unsigned UART_DATA_BITS       = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO; a push while full is only taken if a pop
// frees a slot in the same cycle.
module byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && rd_valid;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_next = count - CW'(1);
        end
    end

    // Storage is cleared on reset so the head byte reads 0 while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= 8'h00;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count    <= count_next;
            rd_valid <= (count_next != '0);
        end
    end

endmodule

// File: rtl/uart_rx_stage.sv
// 8N1 UART receiver: line synchroniser, deserialising FSM and a byte FIFO
// drained through a ready/valid port.
module uart_rx_stage
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned DEPTH        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT    = BW'(UART_DATA_BITS - 1);

    rx_state_t     state;
    logic          rx_m;
    logic          rx_s;
    logic          rx_d;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bit_idx;
    logic [7:0]    shreg;
    logic          push;
    logic          pop;
    logic          full;

    // Two-flop synchroniser plus edge register, all idling high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx_i;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign push = (state == STOP) && (cnt == '0) && rx_s;
    assign pop  = rd_valid && rd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= 8'h00;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_d && !rx_s) begin
                        state <= START;
                        cnt   <= HALF_RELOAD;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                            cnt     <= BIT_RELOAD;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        shreg <= {rx_s, shreg[7:1]};
                        cnt   <= BIT_RELOAD;
                        if (bit_idx == LAST_BIT) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == '0) begin
                        if (rx_s) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            overrun <= full && !pop;
                        end else begin
                            state     <= WAIT_IDLE;
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                WAIT_IDLE: begin
                    // Hold off until the line recovers so a break is not
                    // mistaken for a new start bit.
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    byte_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(shreg),
        .pop      (pop),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .full     (full)
    );

endmodule

// File: tb/tb_uart_rx_stage.sv
// Bench for uart_rx_stage: serialises frames onto rx_i and compares drained
// bytes and error pulses against a queue-based model of the receiver.
module tb_uart_rx_stage;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_i;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int exp_fe = 0;
    int exp_ov = 0;
    logic [7:0] q[$];

    uart_rx_stage #(
        .CLKS_PER_BIT(CPB),
        .DEPTH       (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_i     (rx_i),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Consumer side of the model: every accepted byte must match the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) fe_cnt++;
            if (overrun)   ov_cnt++;
            if (rd_valid && rd_ready) begin
                if (q.size() == 0) check("pop_unexpected", 32'(rd_data), 32'hxxxx_dead);
                else               check("pop_data", 32'(rd_data), 32'(q.pop_front()));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rx_i = v;
        cycles(CPB);
    endtask

    // Model decides the frame's fate up front: good bytes queue if room, else overrun.
    task automatic tx_frame(input logic [7:0] b, input logic stop_ok);
        if (stop_ok) begin
            if (q.size() < DEPTH) q.push_back(b);
            else exp_ov++;
        end else begin
            exp_fe++;
        end
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_ok);
    endtask

    task automatic idle(input int n);
        rx_i = 1'b1;
        if (n > 0) cycles(n);
    endtask

    task automatic wait_drained(input string tag);
        for (int i = 0; i < 200 && rd_valid; i++) cycles(1);
        check(tag, 32'(rd_valid), 32'h0);
    endtask

    task automatic glitch(input int len);
        rx_i = 1'b0;
        cycles(len);
        idle(14);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [7:0] b;
        logic ok;

        rst = 1'b1;
        rx_i = 1'b1;
        rd_ready = 1'b0;
        cycles(2);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        idle(5);

        // Single frame: latency, data, and busy low once the byte appears.
        lat = 0;
        fork
            tx_frame(8'hA5, 1'b1);
            begin
                for (int i = 0; i < 400; i++) begin
                    @(posedge clk);
                    #1;
                    lat++;
                    if (rd_valid) break;
                end
            end
        join_any
        check("latency", 32'(lat), 155);
        check("a5_data", 32'(rd_data), 32'hA5);
        check("a5_busy", 32'(busy), 0);
        wait fork;
        check("a5_frame_err", 32'(fe_cnt), 0);
        rd_ready = 1'b1;
        wait_drained("a5_drain");
        idle(10);

        // Back-to-back frames with no idle gap.
        tx_frame(8'h00, 1'b1);
        tx_frame(8'hFF, 1'b1);
        tx_frame(8'h3C, 1'b1);
        idle(20);
        check("b2b_all_popped", 32'(q.size()), 0);
        check("b2b_no_fe", 32'(fe_cnt), 32'(exp_fe));
        check("b2b_no_ov", 32'(ov_cnt), 32'(exp_ov));

        // Overrun with the consumer stalled.
        rd_ready = 1'b0;
        for (int i = 1; i <= 5; i++) tx_frame(8'(i), 1'b1);
        idle(10);
        check("ovr_pulses", 32'(ov_cnt), 32'(exp_ov));
        check("ovr_exactly_one", 32'(exp_ov), 1);
        check("ovr_valid", 32'(rd_valid), 1);
        check("ovr_head", 32'(rd_data), 32'h01);
        rd_ready = 1'b1;
        wait_drained("ovr_drain");
        check("ovr_model_empty", 32'(q.size()), 0);
        idle(10);

        // Framing error followed by a held-low break.
        tx_frame(8'h55, 1'b0);
        cycles(40);
        check("fe_pulse", 32'(fe_cnt), 32'(exp_fe));
        check("fe_wait_busy", 32'(busy), 1);
        check("fe_no_push", 32'(rd_valid), 0);
        idle(6);
        check("fe_released", 32'(busy), 0);
        tx_frame(8'h66, 1'b1);
        idle(10);
        check("fe_next_good", 32'(q.size()), 0);

        // Short glitch rejected in START.
        rx_i = 1'b0;
        cycles(4);
        check("glitch_busy", 32'(busy), 1);
        rx_i = 1'b1;
        cycles(20);
        check("glitch_idle", 32'(busy), 0);
        check("glitch_no_push", 32'(rd_valid), 0);
        check("glitch_no_fe", 32'(fe_cnt), 32'(exp_fe));

        // Reset mid-frame with one byte queued.
        rd_ready = 1'b0;
        tx_frame(8'h11, 1'b1);
        idle(5);
        check("pre_rst_valid", 32'(rd_valid), 1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        #3;
        rst = 1'b1;
        rx_i = 1'b1;
        q.delete();
        #1;
        check("rst_mid_valid", 32'(rd_valid), 0);
        check("rst_mid_busy", 32'(busy), 0);
        cycles(2);
        rst = 1'b0;
        idle(10);
        check("post_rst_idle", 32'(busy), 0);
        rd_ready = 1'b1;
        tx_frame(8'h7E, 1'b1);
        idle(10);
        check("post_rst_rx", 32'(q.size()), 0);

        // Randomised traffic with glitches and occasional bad stop bits.
        for (int n = 0; n < 14; n++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(5) != 0);
            if ($urandom_range(3) == 0) glitch(int'($urandom_range(6, 1)));
            tx_frame(b, ok);
            idle(ok ? int'($urandom_range(3)) : 4 + int'($urandom_range(8)));
        end
        idle(30);
        check("rand_drained", 32'(q.size()), 0);
        check("rand_fe", 32'(fe_cnt), 32'(exp_fe));
        check("rand_ov", 32'(ov_cnt), 32'(exp_ov));
        check("rand_busy", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_stage.md
# uart_rx_stage

Receive front end of the `tt_um_JayChen2260` user project, fed from `ui_in[0]`. It synchronises the serial line, deserialises 8N1 UART frames, and buffers received bytes in a small FIFO. Downstream logic drains bytes through a ready/valid port. The block also reports framing errors and overruns as single-cycle pulses suitable for sticky status bits on `uo_out`.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per bit. Must be even and ≥ 4.
- `DEPTH`, 4: FIFO depth in bytes. Must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset. Asynchronous and active-high; the top level drives it as `~rst_n`.
- `rx_i`  in  1  raw serial line; idle level 1.
- `rd_data`  out  8  FIFO head byte; valid only while `rd_valid` is high.
- `rd_valid`  out  1  FIFO not empty.
- `rd_ready`  in  1  consumer accepts the head byte when `rd_valid && rd_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: completed byte dropped because the FIFO was full.
- `busy`  out  1  receiver FSM not in IDLE.

## Operation
- Synchroniser: `rx_i` passes through a 2-FF synchroniser (reset value 1) into `rx_s`. An edge register `rx_d` holds `rx_s` from the previous cycle.
- FSM states are IDLE, START, DATA, STOP and WAIT_IDLE.
- **IDLE:** on `rx_d==1 && rx_s==0`, go to START and load the bit counter with `CLKS_PER_BIT/2 - 1`.
- **START:** when the counter reaches 0, sample `rx_s`.
  - Sample 0: go to DATA, with bit index 0 and counter `CLKS_PER_BIT-1`.
  - Sample 1: treat as a glitch and return to IDLE. No error is flagged.
- **DATA:** on each counter expiry, shift `rx_s` into the shift register LSB-first and reload the counter.
  - After the 8th sample, go to STOP.
- **STOP:** on counter expiry, sample `rx_s`.
  - Sample 1: push the byte and go to IDLE.
  - Sample 0: pulse `frame_err`, discard the byte, and go to WAIT_IDLE.
- **WAIT_IDLE:** stay until `rx_s==1`, then go to IDLE. This prevents a break condition from re-triggering the receiver.
- FIFO behaviour (first-word-fall-through):
  - `rd_data` = `mem[rd_ptr]`.
  - Pointers are `log2(DEPTH)` bits wide and wrap naturally.
  - The occupancy counter is `log2(DEPTH)+1` bits wide.
- Push when full without a same-cycle pop: drop the byte, pulse `overrun`, leave FIFO contents unchanged.
- Push when full with a same-cycle pop: accept the byte. Occupancy stays at DEPTH and no overrun is flagged.
- Push and pop in the same cycle when not full or empty: occupancy is unchanged.
- Pop when empty: cannot occur, because `rd_valid` is 0.

## Timing
- Reset values:
  - FSM = IDLE, pointers and count = 0.
  - `rd_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0.
  - `rd_data`=8'h00 (memory is cleared on reset).
- Let cycle 0 be the cycle in which the falling edge is detected in IDLE.
  - Start-bit sample: cycle `CLKS_PER_BIT/2`.
  - Data bit k sample: cycle `CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT`.
  - Stop sample: cycle `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT`.
- Push, `frame_err` and `overrun` are all registered at the stop sample. `rd_valid` rises, or the new byte becomes visible, on the following cycle.
- Latency from the `rx_i` falling edge to `rd_valid`: `2 + 1 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT` cycles. This is 155 cycles at the default (synchroniser 2, edge register 1, stop-bit sample point 152).
- `busy` is high from the cycle after edge detection until the cycle after leaving STOP or WAIT_IDLE.
- A pop takes effect at the clock edge. The next head byte, or `rd_valid`=0, is visible on the following cycle.
- A new start edge is accepted in the first IDLE cycle after STOP, so back-to-back frames with one stop bit are received.
- `rst` asserted mid-frame: the partial byte is lost and the FIFO is emptied immediately (asynchronous). After release, the receiver waits for a fresh falling edge.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum `rx_state_t`.
  - Default `CLKS_PER_BIT`.
  - Constant `UART_DATA_BITS` = 8.
- One natural sub-module: `byte_fifo` (parameter DEPTH; push/pop, full/empty, count). The FSM and synchroniser stay in `uart_rx_stage`.
- Expected RTL size: ~250 lines total.

## Test plan
- Single frame 8'hA5 at 16 clk/bit, `rd_ready`=0 → `rd_valid` rises 155 cycles after the `rx_i` falling edge, with `rd_data`=8'hA5, `frame_err`=0 and `busy` then low.
- Back-to-back frames 8'h00, 8'hFF, 8'h3C with no idle gap, `rd_ready`=1 → bytes pop in that order and no errors are flagged.
- Five frames 8'h01–8'h05 with `rd_ready`=0 and DEPTH=4 → FIFO holds 8'h01–8'h04 and `overrun` pulses once at the 5th stop sample. Draining then yields 01, 02, 03, 04 and `rd_valid` falls.
- Frame 8'h55 with the stop bit forced 0, followed by the line held low for 40 cycles → `frame_err` pulses once, nothing is pushed, FSM stays in WAIT_IDLE until the line goes high, and the next good 8'h66 is received.
- Glitch: `rx_i` low for 4 cycles only → FSM returns to IDLE from START with no push and no error.
- Assert `rst` during DATA of frame 8'h81 with one byte already queued → `rd_valid`=0 immediately. After release, a new frame 8'h7E is received correctly.
